// File: rtl/piece_bag_generator_pkg.sv
// Shared piece codes, bag size, FSM state encodings and the mod-(i+1) fold
// table used by the 7-bag shuffler.
package piece_bag_generator_pkg;

    localparam logic [2:0] PIECE_I    = 3'd0;
    localparam logic [2:0] PIECE_O    = 3'd1;
    localparam logic [2:0] PIECE_T    = 3'd2;
    localparam logic [2:0] PIECE_S    = 3'd3;
    localparam logic [2:0] PIECE_Z    = 3'd4;
    localparam logic [2:0] PIECE_J    = 3'd5;
    localparam logic [2:0] PIECE_L    = 3'd6;
    localparam logic [2:0] PIECE_NONE = 3'd7;

    localparam int unsigned BAG_SIZE = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_SHUF = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // r mod (i+1) for r in 0..7 and i in 1..6, without a divider.
    function automatic logic [2:0] mod_fold(input logic [2:0] r, input logic [2:0] i);
        logic [2:0] res;
        res = '0;
        case (i)
            3'd6:    res = (r == 3'd7) ? 3'd0 : r;
            3'd5:    res = (r >= 3'd6) ? r - 3'd6 : r;
            3'd4:    res = (r >= 3'd5) ? r - 3'd5 : r;
            3'd3:    res = r & 3'd3;
            3'd2:    res = (r >= 3'd6) ? r - 3'd6 : ((r >= 3'd3) ? r - 3'd3 : r);
            3'd1:    res = r & 3'd1;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/piece_bag_generator_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting,
// holding whenever the clock enable is low.
module piece_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        iResetn,
    input  logic        iEn,
    output logic [15:0] oRand
);

    logic [15:0] state;
    logic        feedback;

    assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];
    assign oRand    = state;

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state <= SEED;
        end else if (iEn) begin
            state <= {feedback, state[15:1]};
        end
    end

endmodule

// File: rtl/piece_bag_generator.sv
// 7-bag generator: Fisher-Yates shuffle of piece codes driven by an LFSR,
// with combinational piece/preview reads by bag index.
module piece_bag_generator
    import piece_bag_generator_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iEn,
    input  logic       iGenerate,
    input  logic [2:0] iIndex,
    output logic       oGenDone,
    output logic [2:0] oPiece,
    output logic [2:0] oPreview
);

    logic [1:0]  state;
    logic [2:0]  idx;
    logic        done_r;
    logic [2:0]  bag [BAG_SIZE];
    logic [15:0] rand_val;
    logic [2:0]  j;
    logic [2:0]  val_i;
    logic [2:0]  val_j;
    logic        unused_rand;

    piece_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .iResetn (iResetn),
        .iEn     (iEn),
        .oRand   (rand_val)
    );

    assign unused_rand = ^rand_val[15:3];
    assign j           = mod_fold(rand_val[2:0], idx);
    assign oGenDone    = done_r;

    always_comb begin
        val_i = '0;
        val_j = '0;
        for (int unsigned k = 0; k < BAG_SIZE; k++) begin
            if (3'(k) == idx) val_i = bag[k];
            if (3'(k) == j)   val_j = bag[k];
        end
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state  <= ST_IDLE;
            idx    <= '0;
            done_r <= 1'b0;
            for (int unsigned k = 0; k < BAG_SIZE; k++) bag[k] <= 3'(k);
        end else if (iEn) begin
            case (state)
                ST_IDLE: begin
                    if (iGenerate) state <= ST_INIT;
                end
                ST_INIT: begin
                    for (int unsigned k = 0; k < BAG_SIZE; k++) bag[k] <= 3'(k);
                    idx   <= 3'd6;
                    state <= ST_SHUF;
                end
                ST_SHUF: begin
                    // j == idx lands both writes on one slot with the same value.
                    for (int unsigned k = 0; k < BAG_SIZE; k++) begin
                        if (3'(k) == idx)    bag[k] <= val_j;
                        else if (3'(k) == j) bag[k] <= val_i;
                    end
                    if (idx == 3'd1) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (!iGenerate) begin
                        state  <= ST_IDLE;
                        done_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        oPiece   = PIECE_NONE;
        oPreview = PIECE_NONE;
        for (int unsigned k = 0; k < BAG_SIZE; k++) begin
            if (3'(k) == iIndex) oPiece = bag[k];
            if (iIndex != 3'd7 && 3'(k) == iIndex + 3'd1) oPreview = bag[k];
        end
    end

endmodule
